// File: rtl/nes_pad_pkg.sv
// Purpose: shared types and constants for the NES/Famicom pad reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Configuration: NES_PAD_DETECT_EN selects a 16-bit frame with pad detection.
// Without it, the frame is 8 bits.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETUP,
    PULSE,
    DONE
  } state_e;

  // Bit positions in the parallel button vector (active high).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

`ifdef NES_PAD_DETECT_EN
  // Bits 8..15 of an official pad always read "pressed" and identify the pad.
  localparam int NBITS = 16;
`else
  localparam int NBITS = 8;
`endif

  localparam int BIT_W = $clog2(NBITS);

endpackage

// File: rtl/nes_pad_sync.sv
// Purpose: 2-flop synchronizer for an asynchronous user-port input.
// Latency: 2 clk_i cycles from d_i to q_o.
// Backpressure: none; free-running.
// Ports: clk_i clock, rst_ni async active-low reset, d_i async input,
//        q_o synchronized output. Resets to 1, the released level of a pulled-up line.
module nes_pad_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/nes_pad_reader.sv
// Purpose: NES/Famicom pad initiator; drives latch/pulse and shifts in the buttons.
// Latency: buttons/buttons_valid update one cycle after the final bit sample.
// Backpressure: none; polls every POLL_CYCLES while enable is high.
// Ports: clk_sys, reset_n (async active-low), enable (gates new frames),
//        pad_latch/pad_pulse to the pad, pad_data from the pad (async, low = pressed),
//        buttons[7:0] active high (A,B,Select,Start,Up,Down,Left,Right), buttons_valid strobe,
//        pad_present. Configuration macro: NES_PAD_DETECT_EN (16-bit frame + detection).
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES    = 600,
  parameter int HALF_BIT_CYCLES = 300,
  parameter int POLL_CYCLES     = 833333
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  output logic       pad_latch,
  output logic       pad_pulse,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       pad_present
);

  localparam int PER_W  = $clog2(POLL_CYCLES + 1);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PER_W-1:0] PER_MAX   = '1;
  localparam logic [PER_W-1:0] PER_START = PER_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]  LAT_LAST  = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(HALF_BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);

  state_e             state_q;
  logic [PH_W-1:0]    cnt_q;
  logic [BIT_W-1:0]   bitcnt_q;
  logic [NBITS-1:0]   shreg_q;
  logic [NBITS-1:0]   shreg_d;
  logic [PER_W-1:0]   per_q;
  logic               first_q;
  logic               latch_q;
  logic               pulse_q;
  logic [7:0]         buttons_q;
  logic [7:0]         buttons_d;
  logic               valid_q;
  logic               present_q;
  logic               present_d;
  logic               data_s;

  nes_pad_sync u_sync (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .d_i    (pad_data),
    .q_o    (data_s)
  );

  // Shift register including the bit being sampled this cycle, so the final
  // bit can be published in the same edge that captures it.
  always_comb begin
    shreg_d           = shreg_q;
    shreg_d[bitcnt_q] = ~data_s;
  end

`ifdef NES_PAD_DETECT_EN
  // An absent pad floats high, so its identity bits read as released.
  assign present_d = (shreg_d[15:8] == 8'hFF);
  assign buttons_d = present_d ? shreg_d[7:0] : 8'h00;
`else
  assign present_d = 1'b1;
  assign buttons_d = shreg_d[7:0];
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      per_q     <= '0;
      first_q   <= 1'b1;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Period counter saturates so a long disabled stretch still starts at once.
      if (per_q != PER_MAX) begin
        per_q <= per_q + PER_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (enable && (first_q || per_q >= PER_START)) begin
            state_q  <= LATCH;
            latch_q  <= 1'b1;
            per_q    <= '0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
          end
        end

        LATCH: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= SETUP;
            latch_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + PH_W'(1);
          end
        end

        SETUP: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            shreg_q <= shreg_d;
            if (bitcnt_q == BIT_LAST) begin
              state_q   <= DONE;
              buttons_q <= buttons_d;
              present_q <= present_d;
              valid_q   <= 1'b1;
            end else begin
              state_q <= PULSE;
              pulse_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + PH_W'(1);
          end
        end

        PULSE: begin
          if (cnt_q == HALF_LAST) begin
            state_q  <= SETUP;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= bitcnt_q + BIT_W'(1);
          end else begin
            cnt_q <= cnt_q + PH_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pad_latch     = latch_q;
  assign pad_pulse     = pulse_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign pad_present   = present_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;

  localparam int LAT  = 4;
  localparam int HALF = 3;
  localparam int POLL = 200;
`ifdef NES_PAD_DETECT_EN
  localparam int NB  = 16;
  localparam bit DET = 1'b1;
`else
  localparam int NB  = 8;
  localparam bit DET = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_pulse;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       pad_present;

  int checks = 0;
  int passes = 0;

  nes_pad_reader #(
    .LATCH_CYCLES    (LAT),
    .HALF_BIT_CYCLES (HALF),
    .POLL_CYCLES     (POLL)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .enable        (enable),
    .pad_latch     (pad_latch),
    .pad_pulse     (pad_pulse),
    .pad_data      (pad_data),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .pad_present   (pad_present)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad model: 4021-style shift register, loads on latch, shifts on pulse fall,
  // fills with "pressed" so bits 8..15 read low like an official pad.
  logic [7:0]  pad_btn    = 8'h00;
  logic        pad_absent = 1'b0;
  logic [15:0] pad_sr     = 16'hFF00;
  always @(posedge pad_latch or negedge pad_pulse) begin
    if (pad_latch) pad_sr <= {8'hFF, pad_btn};
    else           pad_sr <= {1'b1, pad_sr[15:1]};
  end
  assign pad_data = pad_absent ? 1'b1 : ~pad_sr[0];

  // Protocol monitor, sampled on the falling edge.
  int   cyc = 0;
  int   lat_run = 0, lat_len = 0, pul_run = 0, pul_cnt = 0, pul_bad = 0;
  int   since_lat = 0, latch_rises = 0, valid_cnt = 0, proto_err = 0;
  logic latch_prev = 1'b0, pulse_prev = 1'b0;
  always @(negedge clk_sys) begin
    cyc++;
    if (!reset_n) begin
      lat_run = 0; pul_run = 0; pul_cnt = 0; pul_bad = 0; since_lat = 0;
      latch_prev = 1'b0; pulse_prev = 1'b0;
    end else begin
      if (pad_latch && pad_pulse) proto_err++;
      if (pad_latch) begin
        if (!latch_prev) begin
          latch_rises++; pul_cnt = 0; pul_bad = 0; lat_run = 0;
        end
        lat_run++;
        since_lat = 0;
      end else begin
        if (latch_prev) lat_len = lat_run;
        since_lat++;
      end
      if (pad_pulse) begin
        if (!pulse_prev && since_lat <= HALF) proto_err++;
        pul_run++;
      end else if (pulse_prev) begin
        pul_cnt++;
        if (pul_run != HALF) pul_bad++;
        pul_run = 0;
      end
      if (buttons_valid) valid_cnt++;
      latch_prev = pad_latch;
      pulse_prev = pad_pulse;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms (want finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (buttons_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s: buttons_valid got 0 for 600 cycles, want 1", name);
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    bit         absent;
    logic [7:0] exp_btn;
    bit         exp_pres;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok;
    int prev_v;
    int v0, r0, n;

    tbl[0] = '{8'h09, 1'b0, 8'h09, 1'b1};  // A + Start
    tbl[1] = '{8'h80, 1'b0, 8'h80, 1'b1};  // Right
    tbl[2] = '{8'h80, 1'b0, 8'h80, 1'b1};  // Right, second frame
    tbl[3] = '{8'h40, 1'b0, 8'h40, 1'b1};  // Left
    tbl[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    tbl[5] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    tbl[6] = '{8'h3C, 1'b1, 8'h00, !DET};  // no pad: line pulled high
    tbl[7] = '{8'hA5, 1'b0, 8'hA5, 1'b1};

    pad_btn    = tbl[0].pat;
    pad_absent = tbl[0].absent;
    enable     = 1'b1;
    reset_n    = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {20'd0, pad_latch, pad_pulse, buttons, buttons_valid, pad_present}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("first_latch_after_reset", pad_latch, 1);

    prev_v = -1;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("vec%0d_valid", i), ok);
      if (ok) begin
        chk($sformatf("vec%0d_buttons", i), buttons, tbl[i].exp_btn);
        chk($sformatf("vec%0d_present", i), pad_present, tbl[i].exp_pres);
        chk($sformatf("vec%0d_latch_len", i), lat_len, LAT);
        chk($sformatf("vec%0d_pulse_count", i), pul_cnt, NB - 1);
        chk($sformatf("vec%0d_pulse_width_errs", i), pul_bad, 0);
        if (prev_v >= 0) chk($sformatf("vec%0d_valid_interval", i), cyc - prev_v, POLL);
        prev_v = cyc;
        if (i < 7) begin
          pad_btn    = tbl[i+1].pat;
          pad_absent = tbl[i+1].absent;
        end
        tick();
        chk($sformatf("vec%0d_valid_one_cycle", i), buttons_valid, 0);
      end else begin
        prev_v = -1;
      end
    end

    // enable dropped during the pulse of bit 3: frame still completes once.
    pad_btn    = 8'h33;
    pad_absent = 1'b0;
    n = 0;
    while (!pad_latch && n < 400) begin tick(); n++; end
    chk("en_latch_seen", pad_latch, 1);
    n = 0;
    while (!(pad_pulse && pul_cnt == 3) && n < 100) begin tick(); n++; end
    chk("en_pulse3_seen", pad_pulse && pul_cnt == 3, 1);
    enable = 1'b0;
    v0 = valid_cnt;
    r0 = latch_rises;
    wait_valid("en_frame_valid", ok);
    if (ok) chk("en_frame_buttons", buttons, 8'h33);
    repeat (300) tick();
    chk("en_valid_once", valid_cnt - v0, 1);
    chk("en_no_latch_while_disabled", latch_rises - r0, 0);
    chk("en_buttons_held", buttons, 8'h33);
    enable = 1'b1;
    tick();
    chk("en_resume_latch", pad_latch, 1);

    // reset during SETUP of bit 5 aborts the frame.
    pad_btn = 8'h6C;
    n = 0;
    while (!(!pad_pulse && pul_cnt == 5) && n < 100) begin tick(); n++; end
    chk("rst_setup5_seen", !pad_pulse && pul_cnt == 5, 1);
    #1 reset_n = 1'b0;
    #1 chk("rst_async_outputs", {20'd0, pad_latch, pad_pulse, buttons, buttons_valid, pad_present}, 32'd0);
    pad_btn = 8'hC6;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_latch_after_release", pad_latch, 1);
    chk("rst_no_partial_update", buttons, 8'h00);
    wait_valid("rst_frame_valid", ok);
    if (ok) begin
      chk("rst_frame_buttons", buttons, 8'hC6);
      chk("rst_frame_pulse_count", pul_cnt, NB - 1);
      chk("rst_frame_present", pad_present, 1);
    end

    tick();
    chk("protocol_errors", proto_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Initiator end of the Famicom/NES serial controller protocol: drives latch and pulse, and shifts in button data from a real pad on the user port (SNAC-style).
- Outputs a parallel active-high button vector, in the same bit order the core's joystick mapping uses for the Gigatron input port.
- Polls continuously at a fixed period in the clk_sys domain.

Parameters:
- LATCH_CYCLES, 600, clk_sys cycles pad_latch is held high (12 us at 50 MHz).
- HALF_BIT_CYCLES, 300, clk_sys cycles per pulse half-period; also the data setup wait before each sample.
- POLL_CYCLES, 833333, cycles from one latch rise to the next (about 60 Hz); must be at least LATCH_CYCLES + 2 x HALF_BIT_CYCLES x NBITS + 4.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits starting a new poll frame.
- pad_latch  out  1  to pad LATCH, active high.
- pad_pulse  out  1  to pad CLK, active high.
- pad_data  in  1  from pad DATA; asynchronous; low means pressed.
- buttons  out  8  active high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- buttons_valid  out  1  one-cycle strobe when buttons updates.
- pad_present  out  1  pad detected (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; FSM returns to IDLE; shift register and counters cleared. Reset mid-frame aborts the frame immediately, with no partial update.
- pad_data passes through a 2-flop synchronizer before use. All sample points below refer to the synchronized value.
- NBITS = 8, or 16 with the optional feature.
- Single poll-period counter runs from latch rise. Its width is $clog2(POLL_CYCLES+1) and it saturates at its maximum.
- FSM states and transitions:
  - IDLE: pad_latch=0, pad_pulse=0. If enable=1 and the period counter >= POLL_CYCLES-1 (or first frame after reset), go to LATCH and zero the period counter.
  - LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles, then go to SETUP.
  - SETUP: both outputs low for HALF_BIT_CYCLES cycles. In the last cycle, shift ~data into shreg at bit index bitcnt (LSB first; the first bit is A). Then:
    - if bitcnt = NBITS-1, go to DONE;
    - otherwise go to PULSE.
  - PULSE: pad_pulse=1 for HALF_BIT_CYCLES cycles; bitcnt increments on exit; go to SETUP.
  - DONE: one cycle. buttons <= shreg[7:0], buttons_valid=1, pad_present updated; go to IDLE.
- Exactly NBITS-1 pulse high phases per frame. pad_latch and pad_pulse are never high simultaneously.
- enable is checked only in IDLE. Deasserting it mid-frame completes the current frame. While enable=0, buttons holds its last value.
- If POLL_CYCLES is smaller than the frame length, the next frame starts on the cycle after DONE.
- Outputs are registered. buttons_valid rises the cycle after the final sample.

Optional Feature:
- Macro NES_PAD_DETECT_EN.
- Defined: NBITS=16. An official pad returns "pressed" (line low) for bits 8..15, while an absent pad reads high through the pull-up.
  - pad_present <= (shreg[15:8] == 8'hFF) at DONE.
  - If the pad is absent, buttons <= 8'h00 instead of the raw bits.
- Undefined: NBITS=8; pad_present is driven to 1 after the first DONE and 0 only in reset.

Decomposition:
- Package nes_pad_pkg:
  - state enum {IDLE, LATCH, SETUP, PULSE, DONE};
  - button index localparams (BTN_A=0 .. BTN_RIGHT=7);
  - NBITS derived from the macro.
- One natural sub-module: nes_pad_sync, a 2-flop synchronizer with async active-low reset that resets to 1 (released). It is reusable for other user-port inputs.

Test Plan:
Bench parameters: LATCH_CYCLES=4, HALF_BIT_CYCLES=3, POLL_CYCLES=200. The pad model is a shift register that loads on latch high and shifts on the pulse falling edge, driving ~bits, with idle-fill low for bits 8..15.
- Pad holding A+Start (8'b0000_1001) -> buttons=8'h09 at the first buttons_valid; latch high 4 cycles; 7 pulses per frame in 8-bit mode (15 in 16-bit mode), each high 3 cycles.
- Pad with Right only, then Left only after 2 frames -> buttons goes 8'h80, then 8'h40; buttons_valid strobes are exactly 200 cycles apart.
- pad_data held high (no pad), with NES_PAD_DETECT_EN -> pad_present=0, buttons=8'h00. Without the macro -> buttons=8'h00, pad_present=1.
- enable dropped during PULSE of bit 3 -> the frame completes with buttons_valid=1 once; no further latch while enable=0; polling resumes within 1 cycle of enable rising if 200 cycles have elapsed.
- reset_n pulsed low during SETUP of bit 5 -> outputs 0 asynchronously; buttons unchanged by the aborted frame; new latch starts right after release.
- Protocol assertion over all tests: never (pad_latch & pad_pulse), and no pad_pulse activity within LATCH_CYCLES.
